// File: rtl/param_siso_shift_reg.sv
// DEPTH-stage x WIDTH-bit serial-in/serial-out shift register with per-stage valid bits, parallel load, flush and fill count.
// Optional SISO_BIDIR_EN adds a dir input for left shifting; dout lags din by DEPTH shift edges.
module param_siso_shift_reg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
`ifdef SISO_BIDIR_EN
  input  logic                   dir,
`endif
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   load,
  input  logic [WIDTH*DEPTH-1:0] pdin,
  input  logic                   flush,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [WIDTH*DEPTH-1:0] pdout,
  output logic [CW-1:0]          fill,
  output logic                   full,
  output logic                   empty
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0]            vld_q;
  logic [CW-1:0]               fill_q;
  logic                        shift_left;
  logic                        out_vld_old;
  logic [CW-1:0]               fill_nxt;

`ifdef SISO_BIDIR_EN
  // Output tap follows the direction of the most recent edge, so dout never depends on dir combinationally.
  logic left_q;

  assign shift_left = dir;

  always_ff @(posedge clk) begin
    if (rst) left_q <= 1'b0;
    else     left_q <= dir;
  end

  assign dout       = left_q ? stage_q[0] : stage_q[DEPTH-1];
  assign dout_valid = left_q ? vld_q[0]   : vld_q[DEPTH-1];
`else
  assign shift_left = 1'b0;
  assign dout       = stage_q[DEPTH-1];
  assign dout_valid = vld_q[DEPTH-1];
`endif

  // The stage leaving the register on this shift decides whether fill drops.
  always_comb begin
    out_vld_old = shift_left ? vld_q[0] : vld_q[DEPTH-1];
    fill_nxt    = fill_q;
    if (din_valid && !out_vld_old)      fill_nxt = fill_q + CW'(1);
    else if (!din_valid && out_vld_old) fill_nxt = fill_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      vld_q   <= '0;
      fill_q  <= '0;
    end else if (flush) begin
      vld_q   <= '0;
      fill_q  <= '0;
    end else if (load) begin
      stage_q <= pdin;
      vld_q   <= '1;
      fill_q  <= CW'(DEPTH);
    end else if (en) begin
      if (shift_left) begin
        stage_q <= {din, stage_q[DEPTH-1:1]};
        vld_q   <= {din_valid, vld_q[DEPTH-1:1]};
      end else begin
        stage_q <= {stage_q[DEPTH-2:0], din};
        vld_q   <= {vld_q[DEPTH-2:0], din_valid};
      end
      fill_q <= fill_nxt;
    end
  end

  assign pdout = stage_q;
  assign fill  = fill_q;
  assign full  = (fill_q == CW'(DEPTH));
  assign empty = (fill_q == '0);

endmodule

// File: tb/tb_param_siso_shift_reg.sv
// Scoreboarded bench for param_siso_shift_reg (WIDTH=4, DEPTH=8): directed test-plan sequences plus random traffic.
module tb_param_siso_shift_reg;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   en = 1'b0;
  logic                   dir = 1'b0;
  logic [WIDTH-1:0]       din = '0;
  logic                   din_valid = 1'b0;
  logic                   load = 1'b0;
  logic [WIDTH*DEPTH-1:0] pdin = '0;
  logic                   flush = 1'b0;
  logic [WIDTH-1:0]       dout;
  logic                   dout_valid;
  logic [WIDTH*DEPTH-1:0] pdout;
  logic [CW-1:0]          fill;
  logic                   full;
  logic                   empty;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [WIDTH-1:0]       dout;
    logic                   dv;
    logic [WIDTH*DEPTH-1:0] pdout;
    int                     fill;
    logic                   full;
    logic                   empty;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] md[$];
  bit               mv[$];

  param_siso_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef SISO_BIDIR_EN
    .dir(dir),
`endif
    .din(din), .din_valid(din_valid), .load(load), .pdin(pdin), .flush(flush),
    .dout(dout), .dout_valid(dout_valid), .pdout(pdout), .fill(fill),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: index 0 is stage 0; a shift pushes the new word at the front and drops the back.
  task automatic model_edge(input logic r, f, l, e, input logic [WIDTH-1:0] d,
                            input logic v, input logic [WIDTH*DEPTH-1:0] p);
    exp_t x;
    int cnt;
    if (r) begin
      md.delete(); mv.delete();
      for (int i = 0; i < DEPTH; i++) begin md.push_back('0); mv.push_back(1'b0); end
    end else if (f) begin
      for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    end else if (l) begin
      for (int i = 0; i < DEPTH; i++) begin md[i] = p[i*WIDTH +: WIDTH]; mv[i] = 1'b1; end
    end else if (e) begin
      md.push_front(d); void'(md.pop_back());
      mv.push_front(v); void'(mv.pop_back());
    end
    cnt = 0;
    x.pdout = '0;
    for (int i = 0; i < DEPTH; i++) begin
      x.pdout[i*WIDTH +: WIDTH] = md[i];
      if (mv[i]) cnt++;
    end
    x.dout  = md[DEPTH-1];
    x.dv    = mv[DEPTH-1];
    x.fill  = cnt;
    x.full  = (cnt == DEPTH);
    x.empty = (cnt == 0);
    sb_q.push_back(x);
  endtask

  task automatic step(input logic r, f, l, e, input logic [WIDTH-1:0] d,
                      input logic v, input logic [WIDTH*DEPTH-1:0] p);
    @(negedge clk);
    rst = r; flush = f; load = l; en = e; din = d; din_valid = v; pdin = p;
    @(posedge clk);
    #1;
    model_edge(r, f, l, e, d, v, p);
  endtask

  // Monitor: every edge presents a full output set; compare it against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      chk("sb_dout", 32'(dout), 32'(x.dout));
      chk("sb_dout_valid", 32'(dout_valid), 32'(x.dv));
      chk("sb_pdout", pdout, x.pdout);
      chk("sb_fill", 32'(fill), x.fill);
      chk("sb_full", 32'(full), 32'(x.full));
      chk("sb_empty", 32'(empty), 32'(x.empty));
    end
  end

  initial begin
    logic [31:0] rnd;
    // Reset for two edges under random inputs.
    for (int i = 0; i < 2; i++) begin
      rnd = $urandom;
      step(1'b1, rnd[0], rnd[1], rnd[2], rnd[7:4], rnd[3], $urandom);
    end
    chk("rst_dout", 32'(dout), 0);
    chk("rst_dout_valid", 32'(dout_valid), 0);
    chk("rst_pdout", pdout, 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);

    // Fill with 1..8, then one more shift.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 1'b1, '0);
    chk("fill8_dout", 32'(dout), 1);
    chk("fill8_dout_valid", 32'(dout_valid), 1);
    chk("fill8_fill", 32'(fill), 8);
    chk("fill8_full", 32'(full), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, '0);
    chk("shift9_dout", 32'(dout), 2);
    chk("shift9_fill", 32'(fill), 8);

    // Same stream with a 3-edge enable gap after the 4th value.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      rnd = $urandom;
      step(1'b0, 1'b0, 1'b0, 1'b0, rnd[3:0], rnd[4], '0);
      chk("gap_fill_hold", 32'(fill), 4);
    end
    for (int i = 5; i <= 7; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 1'b1, '0);
    chk("gap_7th_dout_valid", 32'(dout_valid), 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd8, 1'b1, '0);
    chk("gap_8th_dout", 32'(dout), 1);
    chk("gap_8th_dout_valid", 32'(dout_valid), 1);

    // Parallel load, then drain with invalid input.
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 1'b1, 32'hFEDC_BA98);
    chk("load_full", 32'(full), 1);
    for (int k = 0; k < 8; k++) begin
      chk("drain_dout", 32'(dout), 32'(15 - k));
      chk("drain_fill", 32'(fill), 32'(8 - k));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, '0);
    end
    chk("drain_end_fill", 32'(fill), 0);
    chk("drain_end_empty", 32'(empty), 1);

    // Flush beats load; reset beats load.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 1'b1, '0);
    chk("pre_flush_fill", 32'(fill), 5);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b1, 32'hFFFF_FFFF);
    chk("flush_fill", 32'(fill), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_pdout_hold", pdout, 32'h0001_2345);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 1'b1, 32'hFFFF_FFFF);
    chk("rst_load_pdout", pdout, 0);
    chk("rst_load_fill", 32'(fill), 0);

    // Random traffic, mostly shifts.
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      step(rnd[9:0] == 10'd3, rnd[15:11] == 5'd1, rnd[20:16] == 5'd2,
           rnd[21] | rnd[22], rnd[26:23], rnd[27] | rnd[28], $urandom);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/param_siso_shift_reg.md
Name: param_siso_shift_reg

Overview:
- Parametrised successor to the single-stage DFF: a DEPTH-stage, WIDTH-bit-per-stage serial-in/serial-out shift register.
- Adds shift enable, per-stage valid tracking, parallel load/flush and a fill counter.
- Sits in the SEQUENTIAL/SISO library as the general delay-line / serialiser primitive for datapath and bench use.

Parameters:
- WIDTH, 1, bits per stage (lane width); legal range >= 1.
- DEPTH, 8, number of stages; legal range >= 2.
- CW, $clog2(DEPTH+1), width of the fill count (derived; do not override).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  shift enable; one stage advance per clk edge while high.
- din  input  WIDTH  serial data in, captured into stage 0 on shift.
- din_valid  input  1  qualifies din; captured into stage 0's valid bit on shift.
- load  input  1  parallel load of all stages.
- pdin  input  WIDTH*DEPTH  parallel load data; stage i = pdin[i*WIDTH +: WIDTH].
- flush  input  1  clears all valid bits; data bits untouched.
- dout  output  WIDTH  serial data out = stage[DEPTH-1] register.
- dout_valid  output  1  valid bit of stage[DEPTH-1].
- pdout  output  WIDTH*DEPTH  all stage registers, same packing as pdin.
- fill  output  CW  number of stages with valid bit set (0..DEPTH).
- full  output  1  fill == DEPTH.
- empty  output  1  fill == 0.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- All state is updated on the rising clk edge. Outputs are driven directly from registers or from decode of registers, with no input-to-output combinational path.
- Reset (rst=1 at the edge): all stage data = 0, all valid = 0, fill = 0.
  - Resulting outputs: dout=0, dout_valid=0, pdout=0, empty=1, full=0.
  - Reset overrides everything, including reset asserted mid-shift or mid-load.
- Per-edge priority: rst > flush > load > en. Exactly one action per edge.
- flush: valid[*] = 0, fill = 0; data registers hold.
- load: stage[i] = pdin slice i for all i; valid[*] = 1; fill = DEPTH. Ignores en/din.
- Shift (en=1, no higher-priority action):
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1; valid shifts the same way.
  - stage[0] <= din, valid[0] <= din_valid.
  - The old stage[DEPTH-1] is discarded.
  - fill <= fill + din_valid - old valid[DEPTH-1]. Net change is -1, 0 or +1; never wraps.
- Hold (en=0, no other action): all state holds.
- Latency: din captured at shift edge k appears on dout/dout_valid after the DEPTH-th shift edge counting k as the first. Non-shift edges in between do not count.
- Full/empty:
  - A shift with din_valid=1 while full keeps fill = DEPTH if the outgoing stage was valid.
  - A shift with din_valid=0 while empty keeps fill = 0.
- Invalid stages still shift their data bits; consumers qualify dout with dout_valid.

Optional Feature:
- Macro: SISO_BIDIR_EN.
- Defined:
  - Adds input port dir (1 bit, after en).
  - dir=0: right shift exactly as above.
  - dir=1: left shift. stage[i] <= stage[i+1], stage[DEPTH-1] <= din/din_valid; the old stage[0] is discarded.
  - In left-shift mode dout/dout_valid are driven from stage[0], and fill uses old valid[0] as the outgoing bit.
  - Changing dir between edges is legal; the next shift uses the new direction.
- Not defined: no dir port; right shift only; dout always from stage[DEPTH-1].

Test Plan (WIDTH=4, DEPTH=8 unless stated):
- rst=1 for 2 edges with random inputs -> dout=0, dout_valid=0, pdout=0, fill=0, empty=1, full=0.
- en=1, din_valid=1, din=1,2,...,8 on 8 consecutive edges -> after the 8th edge dout=1, dout_valid=1, fill=8, full=1. The next shift with din=9 gives dout=2, fill=8.
- Same stream with en deasserted for 3 edges after the 4th value -> outputs hold during the gap; din=1 reaches dout only after the 8th shift edge, 3 edges later than the no-gap run.
- load=1, pdin=32'hFEDCBA98 -> dout=4'hF, fill=8, full=1. Then 8 shifts with din_valid=0 -> dout sequence F,E,D,C,B,A,9,8 on the edges before, and fill decrements 8 to 0.
- Partial fill to 5, then flush=1 and load=1 on the same edge -> flush wins: fill=0, empty=1, data unchanged. rst=1 together with load=1 -> reset state.
- SISO_BIDIR_EN builds: load 32'h76543210, dir=1, one shift with din=4'hA/din_valid=1 -> dout(stage0)=1, stage7=A, fill=8. Non-BIDIR builds must compile without a dir port.
